// File: rtl/rm_pkg.sv
// Shared types and width helpers for the read-modify pipeline.
// Keeps beat-slicer and aligner widths in lock-step.
package rm_pkg;

    typedef enum logic {
        RM_SLC_IDLE,
        RM_SLC_ACTIVE
    } rm_slc_state_e;

    // Width of an element offset within a beat.
    function automatic int rm_iofs_w(input int ibec);
        return (ibec == 1) ? 1 : $clog2(ibec);
    endfunction

    // Width of an element count 0..IBEC inclusive.
    function automatic int rm_ibec_w(input int ibec);
        return $clog2(ibec + 1);
    endfunction

endpackage

// File: rtl/rm_beat_slicer.sv
// Beat slicer: turns a read descriptor plus its data beats into
// per-beat element windows for the aligner.
module rm_beat_slicer
    import rm_pkg::*;
#(
    parameter  int EW    = 64,
    parameter  int IBEC  = 32,
    parameter  int LENW  = 16,
    parameter  int AW    = 32,
    localparam int IOFSW = rm_iofs_w(IBEC),
    localparam int IBECW = rm_ibec_w(IBEC)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 dval,
    output logic                 drdy,
    input  logic [AW-1:0]        daddr,
    input  logic [LENW-1:0]      dlen,
    input  logic                 dinit,
    input  logic                 bval,
    output logic                 brdy,
    input  logic [IBEC*EW-1:0]   bdata,
    input  logic                 blast,
    output logic                 ival,
    input  logic                 irdy,
    output logic                 init,
    output logic [IBEC*EW-1:0]   ib,
    output logic [IOFSW-1:0]     iofs,
    output logic [IBECW-1:0]     iec,
    output logic                 done,
    output logic                 err
);

    localparam int LW1 = LENW + 1;

    rm_slc_state_e    state;
    logic [LENW-1:0]  rem;
    logic [IOFSW-1:0] ofs;
    logic             first;
    logic             pinit;

    logic [IOFSW-1:0] iofs_c;
    logic [LENW:0]    win;
    logic [LENW:0]    rem_x;
    logic [LENW:0]    iec_w;
    logic [LENW-1:0]  rem_nxt;
    logic             xfer;
    logic             mism;
    logic             unused_ok;

    // Window arithmetic for the beat currently offered.
    assign iofs_c  = first ? ofs : '0;
    assign win     = LW1'(IBEC) - LW1'(iofs_c);
    assign rem_x   = {1'b0, rem};
    assign iec_w   = (rem_x < win) ? rem_x : win;
    assign rem_nxt = rem - iec_w[LENW-1:0];
    assign xfer    = (state == RM_SLC_ACTIVE) & bval & irdy;
    assign mism    = blast != (rem_x == iec_w);

    assign ib   = bdata;
    assign drdy = (state == RM_SLC_IDLE);

    assign unused_ok = ^{daddr, iec_w};

    // Handshake and window outputs are only live while a descriptor runs.
    always_comb begin
        ival = 1'b0;
        brdy = 1'b0;
        iofs = '0;
        iec  = '0;
        init = 1'b0;
        if (state == RM_SLC_ACTIVE) begin
            ival = bval;
            brdy = irdy;
            iofs = iofs_c;
            iec  = iec_w[IBECW-1:0];
            init = first & pinit;
        end
    end

    // Descriptor FSM, remaining-count tracking and status pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RM_SLC_IDLE;
            rem   <= '0;
            ofs   <= '0;
            first <= 1'b0;
            pinit <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                RM_SLC_IDLE: begin
                    if (dval) begin
                        rem   <= dlen;
                        ofs   <= (IBEC == 1) ? '0 : daddr[IOFSW-1:0];
                        first <= 1'b1;
                        pinit <= dinit;
                        if (dlen == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RM_SLC_ACTIVE;
                        end
                    end
                end
                RM_SLC_ACTIVE: begin
                    if (xfer) begin
                        rem   <= rem_nxt;
                        first <= 1'b0;
                        err   <= mism;
                        if (rem_nxt == '0) begin
                            state <= RM_SLC_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= RM_SLC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rm_beat_slicer.sv
// Directed vector bench for rm_beat_slicer (IBEC = 32).
// Each row drives one cycle and checks outputs before the next edge.
module tb_rm_beat_slicer;

    localparam int EW   = 64;
    localparam int IBEC = 32;
    localparam int LENW = 16;
    localparam int AW   = 32;

    logic                 clk;
    logic                 rstn;
    logic                 dval;
    logic                 drdy;
    logic [AW-1:0]        daddr;
    logic [LENW-1:0]      dlen;
    logic                 dinit;
    logic                 bval;
    logic                 brdy;
    logic [IBEC*EW-1:0]   bdata;
    logic                 blast;
    logic                 ival;
    logic                 irdy;
    logic                 init;
    logic [IBEC*EW-1:0]   ib;
    logic [4:0]           iofs;
    logic [5:0]           iec;
    logic                 done;
    logic                 err;

    int nvec;
    int nbad;

    rm_beat_slicer #(
        .EW   (EW),
        .IBEC (IBEC),
        .LENW (LENW),
        .AW   (AW)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .dval  (dval),
        .drdy  (drdy),
        .daddr (daddr),
        .dlen  (dlen),
        .dinit (dinit),
        .bval  (bval),
        .brdy  (brdy),
        .bdata (bdata),
        .blast (blast),
        .ival  (ival),
        .irdy  (irdy),
        .init  (init),
        .ib    (ib),
        .iofs  (iofs),
        .iec   (iec),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        dval;
        logic [31:0] daddr;
        logic [15:0] dlen;
        logic        dinit;
        logic        bval;
        logic        blast;
        logic        irdy;
        logic [16:0] exp;
    } vec_t;

    vec_t tab[$];

    function automatic logic [16:0] ex(
        bit dr, bit br, bit iv, int of, int ec, bit in, bit dn, bit er
    );
        return {dr, br, iv, 5'(of), 6'(ec), in, dn, er};
    endfunction

    function automatic vec_t mk(
        string n, bit dv, int da, int dl, bit di,
        bit bv, bit bl, bit ir, logic [16:0] e
    );
        vec_t v;
        v.name  = n;
        v.dval  = dv;
        v.daddr = 32'(da);
        v.dlen  = 16'(dl);
        v.dinit = di;
        v.bval  = bv;
        v.blast = bl;
        v.irdy  = ir;
        v.exp   = e;
        return v;
    endfunction

    task automatic drive(vec_t v);
        dval  = v.dval;
        daddr = v.daddr;
        dlen  = v.dlen;
        dinit = v.dinit;
        bval  = v.bval;
        blast = v.blast;
        irdy  = v.irdy;
        for (int i = 0; i < IBEC * EW / 32; i++)
            bdata[i*32 +: 32] = $urandom;
    endtask

    task automatic check(string n, logic [16:0] e);
        logic [16:0] g;
        g = {drdy, brdy, ival, iofs, iec, init, done, err};
        nvec++;
        if (g !== e) begin
            nbad++;
            $display("FAIL %s: got drdy=%b brdy=%b ival=%b iofs=%0d iec=%0d init=%b done=%b err=%b, want drdy=%b brdy=%b ival=%b iofs=%0d iec=%0d init=%b done=%b err=%b",
                n, g[16], g[15], g[14], g[13:9], g[8:3], g[2], g[1], g[0],
                e[16], e[15], e[14], e[13:9], e[8:3], e[2], e[1], e[0]);
        end
        nvec++;
        if (ib !== bdata) begin
            nbad++;
            $display("FAIL %s_ib: got ib[63:0]=%h, want %h",
                n, ib[63:0], bdata[63:0]);
        end
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v);
        #2;
        check(v.name, v.exp);
    endtask

    initial begin
        vec_t w;
        nvec = 0;
        nbad = 0;
        rstn = 1'b0;
        drive(mk("z", 0, 0, 0, 0, 0, 0, 0, '0));

        // Single short beat with init.
        tab.push_back(mk("rst",     0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s1_desc", 1,  5, 10, 1, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s1_beat", 0,  0,  0, 0, 1, 1, 1, ex(0,1,1, 5,10,1,0,0)));
        tab.push_back(mk("s1_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,0)));
        // Unaligned three-beat burst.
        tab.push_back(mk("s2_desc", 1, 30, 40, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s2_b1",   0,  0,  0, 0, 1, 0, 1, ex(0,1,1,30, 2,0,0,0)));
        tab.push_back(mk("s2_b2",   0,  0,  0, 0, 1, 0, 1, ex(0,1,1, 0,32,0,0,0)));
        tab.push_back(mk("s2_b3",   0,  0,  0, 0, 1, 1, 1, ex(0,1,1, 0, 6,0,0,0)));
        tab.push_back(mk("s2_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,0)));
        // Zero-length descriptor: no beat accepted.
        tab.push_back(mk("s3_desc", 1,  7,  0, 1, 1, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s3_done", 0,  0,  0, 0, 1, 0, 1, ex(1,0,0, 0, 0,0,1,0)));
        tab.push_back(mk("s3_idle", 0,  0,  0, 0, 1, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        // Two full beats with a gap and a mid-burst stall.
        tab.push_back(mk("s4_desc", 1,  0, 64, 1, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s4_gap",  0,  0,  0, 0, 0, 0, 1, ex(0,1,0, 0,32,1,0,0)));
        tab.push_back(mk("s4_b1",   0,  0,  0, 0, 1, 0, 1, ex(0,1,1, 0,32,1,0,0)));
        tab.push_back(mk("s4_st1",  0,  0,  0, 0, 1, 0, 0, ex(0,0,1, 0,32,0,0,0)));
        tab.push_back(mk("s4_st2",  0,  0,  0, 0, 1, 1, 0, ex(0,0,1, 0,32,0,0,0)));
        tab.push_back(mk("s4_st3",  0,  0,  0, 0, 1, 1, 0, ex(0,0,1, 0,32,0,0,0)));
        tab.push_back(mk("s4_b2",   0,  0,  0, 0, 1, 1, 1, ex(0,1,1, 0,32,0,0,0)));
        tab.push_back(mk("s4_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,0)));
        // Early blast: err on beat 1, burst still completes.
        tab.push_back(mk("s5_desc", 1, 30, 40, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s5_b1",   0,  0,  0, 0, 1, 1, 1, ex(0,1,1,30, 2,0,0,0)));
        tab.push_back(mk("s5_b2",   0,  0,  0, 0, 1, 0, 1, ex(0,1,1, 0,32,0,0,1)));
        tab.push_back(mk("s5_b3",   0,  0,  0, 0, 1, 1, 1, ex(0,1,1, 0, 6,0,0,0)));
        tab.push_back(mk("s5_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,0)));
        // Missing blast on final beat: done and err together.
        tab.push_back(mk("s6_desc", 1,  3,  4, 1, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        tab.push_back(mk("s6_beat", 0,  0,  0, 0, 1, 0, 1, ex(0,1,1, 3, 4,1,0,0)));
        tab.push_back(mk("s6_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,1)));

        repeat (2) @(negedge clk);
        rstn = 1'b1;

        foreach (tab[i]) apply(tab[i]);

        // Asynchronous reset after beat 1 of 3.
        apply(mk("r_desc", 1, 30, 40, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        apply(mk("r_b1",   0,  0,  0, 0, 1, 0, 1, ex(0,1,1,30, 2,0,0,0)));
        @(negedge clk);
        w = mk("r_pre", 0, 0, 0, 0, 1, 0, 1, ex(0,1,1, 0,32,0,0,0));
        drive(w);
        #1;
        check(w.name, w.exp);
        rstn = 1'b0;
        #1;
        check("r_async", ex(1,0,0, 0, 0,0,0,0));
        @(negedge clk);
        rstn = 1'b1;
        apply(mk("r_post", 0,  0,  0, 0, 1, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        apply(mk("r_desc2",1,  5, 10, 1, 0, 0, 1, ex(1,0,0, 0, 0,0,0,0)));
        apply(mk("r_beat", 0,  0,  0, 0, 1, 1, 1, ex(0,1,1, 5,10,1,0,0)));
        apply(mk("r_done", 0,  0,  0, 0, 0, 0, 1, ex(1,0,0, 0, 0,0,1,0)));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/rm_beat_slicer.md
# rm_beat_slicer

Upstream feeder for `rm_aligner`. It accepts a read descriptor (starting element address, element count, init flag) and the stream of full-width data beats returned for that descriptor. For each beat it computes the valid element window (`iofs`, `iec`) and the `init` marker, then forwards the beat on the aligner's input handshake. It sits between the AXI read-data return path and the aligner in the read-modify pipeline.

## Interface
- `EW`, 64: element width, bits
- `IBEC`, 32: elements per beat; must match the aligner's `IBEC`
- `LENW`, 16: descriptor element-count width
- `AW`, 32: descriptor element-address width
- `clk`  in  1  clock
- `rstn`  in  1  reset; asynchronous, active-low
- `dval`  in  1  descriptor valid
- `drdy`  out  1  descriptor ready
- `daddr`  in  AW  start address, in elements
- `dlen`  in  LENW  total elements to deliver
- `dinit`  in  1  assert aligner `init` on this descriptor's first beat
- `bval`  in  1  beat valid
- `brdy`  out  1  beat ready
- `bdata`  in  IBEC*EW  beat data, packed `[IBEC-1:0][EW-1:0]`
- `blast`  in  1  source marks final beat
- `ival`  out  1  to aligner
- `irdy`  in  1  from aligner
- `init`  out  1  to aligner
- `ib`  out  IBEC*EW  to aligner; equals `bdata`
- `iofs`  out  IOFSW  first valid element; IOFSW = (IBEC==1) ? 1 : clog2(IBEC)
- `iec`  out  IBECW  valid element count; IBECW = clog2(IBEC+1)
- `done`  out  1  one-cycle pulse when the descriptor completes
- `err`  out  1  one-cycle pulse on a `blast` mismatch

## Operation
- FSM states: IDLE, ACTIVE.
- IDLE:
  - `drdy` = 1.
  - On `dval`, capture `rem` = `dlen`, `ofs` = `daddr` mod IBEC (low IOFSW bits; 0 when IBEC==1), `first` = 1, and `pinit` = `dinit`.
  - If `dlen` == 0: stay in IDLE and pulse `done` the next cycle. Otherwise go to ACTIVE.
- ACTIVE:
  - Combinational outputs: `ival` = `bval`; `brdy` = `irdy`.
  - `iofs` = `first` ? `ofs` : 0.
  - `iec` = min(IBEC − `iofs`, `rem`), computed at LENW+1 bits and then truncated.
  - `init` = `first` & `pinit`.
- Transfer occurs when `bval` & `irdy`. On a transfer:
  - `rem` −= `iec`; `first` = 0.
  - If the new `rem` == 0: go to IDLE and pulse `done` the next cycle.
- Error check on each transfer: `blast` must equal (`rem` == `iec`). On a mismatch, pulse `err` the next cycle. The beat is still forwarded and the counters still advance. Beats are never dropped and never stretched.
- No beat is accepted in IDLE: `brdy` = 0 and `ival` = 0 there.

## Timing
- Reset values: state = IDLE, `drdy` = 1, `brdy` = 0, `ival` = 0, `init` = 0, `iofs` = 0, `iec` = 0, `done` = 0, `err` = 0. Internal registers are cleared.
- Data path latency is zero: beat to aligner is combinational. `ib` follows `bdata` in every state.
- Descriptor acceptance to first eligible beat: 1 cycle.
- Minimum of one IDLE cycle between descriptors. `drdy` is low for the whole of ACTIVE.
- Stall (`irdy` = 0): `brdy` = 0, all registers hold, outputs stay stable as long as `bdata` is stable.
- `done` and `err` are registered pulses, asserted the cycle after the final or mismatched transfer. Both may assert in the same cycle.
- Asynchronous reset mid-burst: return to IDLE immediately, discard the partial descriptor, no `done` pulse.
- `dlen` larger than one beat window wraps naturally into full beats. The final beat's `iec` may be smaller than IBEC.

## Structure
- Shared package `rm_pkg`: state enum `rm_slc_state_e`, plus width helpers for IOFSW and IBECW so they match the aligner exactly.
- No sub-module. The FSM, counters, and min computation all live in one module.

## Test plan
All scenarios use IBEC = 32.
- `daddr` = 5, `dlen` = 10, `dinit` = 1; one beat with `blast` → `iofs` = 5, `iec` = 10, `init` = 1; `done` the next cycle; `err` = 0.
- `daddr` = 30, `dlen` = 40, `dinit` = 0 → three beats with (`iofs`, `iec`) = (30, 2), (0, 32), (0, 6); `init` = 0 throughout; `done` after the third beat.
- `dlen` = 0 → `done` pulses 1 cycle later; `brdy` stays 0; `drdy` returns high.
- `daddr` = 0, `dlen` = 64; `irdy` low for 3 cycles mid-burst → `brdy` = 0 during the stall; `iofs`/`iec` held; second beat is `iec` = 32; total transferred = 64.
- `daddr` = 30, `dlen` = 40; `blast` asserted on beat 1 → `err` pulses; all three beats still forwarded; `done` after beat 3.
- `rstn` asserted after beat 1 of 3 → outputs return to reset values at once; `drdy` = 1 after release; a new descriptor works normally.
